burst_rr_arbiter: RTL and testbench
===================================

BURST_RR_ARBITER -- requirements
Module: burst_rr_arbiter

Interface
REQ-001 Parameter N, default 4: number of requesters, 2..16.
REQ-002 Parameter MAX_BEATS, default 8: beat limit per grant when the timeout feature is compiled in, 1..255.
REQ-003 Port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 Port rst_n  input  1: reset, asynchronous, active-low.
REQ-005 Port enable  input  1: permits new grants; does not cut off a grant in progress.
REQ-006 Port req  input  N: per-requester request, level; holding req[i] high keeps requester i eligible.
REQ-007 Port beat  input  1: one data beat of the current owner transferred this cycle.
REQ-008 Port last  input  N: per-requester end-of-burst marker, sampled only at index of owner with beat=1.
REQ-009 Port gnt  output  N: registered one-hot grant; all-zero when no owner.
REQ-010 Port valid  output  1: registered; high exactly when gnt is non-zero.
REQ-011 Port timeout  output  1: registered one-cycle pulse on forced release.

Function
REQ-012 The FSM SHALL have two states: IDLE (no owner) and GRANT (one owner holds the resource).
REQ-013 In IDLE with enable=1 and req!=0, the winner SHALL be the first set req bit searched from index ptr+1 upward, wrapping modulo N.
REQ-014 At the next edge: gnt=onehot(winner), valid=1, ptr=winner, beat count=0, state=GRANT (one-cycle request-to-grant latency).
REQ-015 In IDLE with enable=0 or req=0, gnt, valid and ptr SHALL hold.
REQ-016 In GRANT, each cycle with beat=1 SHALL increment the beat counter (8 bits, saturating at 255).
REQ-017 In GRANT, beat=1 with last[owner]=1 SHALL release: next edge gnt=0, valid=0, state=IDLE.
REQ-018 In GRANT, req[owner]=0 SHALL release identically, regardless of beat.
REQ-019 beat=1 in IDLE SHALL be ignored.
REQ-020 After any release, at least one IDLE cycle SHALL occur before the next grant (no direct handoff).
REQ-021 enable falling during GRANT SHALL NOT release; the burst completes normally.
REQ-022 Changes in req or last bits of non-owners during GRANT SHALL have no effect.
REQ-023 gnt SHALL never have more than one bit set; valid SHALL equal |gnt in every cycle.

Reset
REQ-024 On rst_n=0, immediately and asynchronously: gnt=0, valid=0, timeout=0, state=IDLE, beat count=0, ptr=N-1 (requester 0 first priority after reset).
REQ-025 Reset asserted mid-burst SHALL abandon the burst; the first grant after reset follows REQ-013 with ptr=N-1.

Configuration
REQ-026 Macro ARB_TIMEOUT_EN defined: a beat that brings the count to MAX_BEATS without last SHALL release as in REQ-017 and pulse timeout=1 for the release edge's following cycle.
REQ-027 ARB_TIMEOUT_EN undefined: no beat limit; timeout SHALL be tied to 0; the port is still present.
REQ-028 When the limit beat also carries last, the release SHALL be a normal release with timeout=0.

Structure
REQ-029 Shared package arb_pkg SHALL hold the FSM state type (IDLE, GRANT) and the beat counter width constant (8).
REQ-030 Rotating-priority search SHALL be a combinational sub-module rr_pick (inputs req, ptr; outputs one-hot pick and index).

Verification
REQ-031 Reset, then req=4'b1111, enable=1, a beat with last each grant -> grant order 0,1,2,3,0, each grant separated by one IDLE cycle.
REQ-032 ptr=1 (last winner 1), req=4'b1001 -> gnt=4'b1000 next edge; after release, req=4'b1001 -> gnt=4'b0001.
REQ-033 Owner 2 sends 3 beats with last on beat 3 and enable dropped after beat 1 -> gnt=4'b0100 held through beat 3, gnt=0 the edge after.
REQ-034 ARB_TIMEOUT_EN, MAX_BEATS=8, owner 0 streams beats with last=0 -> release after the 8th beat, timeout=1 for one cycle, next grant goes to another requester if pending.
REQ-035 Owner 1 drops req[1] mid-burst with no beat -> gnt=0, valid=0 next edge, timeout=0.
REQ-036 rst_n pulsed low during a grant to requester 3 -> gnt=0 immediately; with req=4'b1000 after reset -> gnt=4'b1000, never two bits set throughout.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the burst round-robin arbiter.
//   arb_state_e : arbiter FSM state (IDLE = no owner, GRANT = one owner)
//   BEAT_CNT_W  : width of the per-grant beat counter
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    localparam int unsigned BEAT_CNT_W = 8;

endpackage : arb_pkg

// File: rtl/burst_rr_arbiter_rr_pick.sv
// rr_pick: combinational rotating-priority search.
// Finds the first set bit of req starting at index ptr+1 and wrapping
// modulo N.
//   req  [N-1:0]  : request vector
//   ptr  [PW-1:0] : index of the previous winner
//   pick [N-1:0]  : one-hot winner (all-zero when req is zero)
//   idx  [PW-1:0] : binary index of the winner (0 when req is zero)
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [PW-1:0] idx
);

    logic        found;
    int unsigned j;

    always_comb begin
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        j     = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && req[PW'(j)]) begin
                found          = 1'b1;
                pick[PW'(j)]   = 1'b1;
                idx            = PW'(j);
            end
        end
    end

endmodule : rr_pick

// File: rtl/burst_rr_arbiter.sv
// burst_rr_arbiter: round-robin arbiter that grants a requester for a whole
// burst. A grant is held until the owner marks the last beat or drops its
// request; at least one idle cycle separates consecutive grants.
// Optional beat limit: define ARB_TIMEOUT_EN to force release after
// MAX_BEATS beats without last (timeout pulses for one cycle).
//   clk, rst_n      : clock, asynchronous active-low reset
//   enable          : permits new grants (never cuts a grant short)
//   req  [N-1:0]    : level requests
//   beat            : one data beat of the owner this cycle
//   last [N-1:0]    : end-of-burst marker, looked at only for the owner
//   gnt  [N-1:0]    : registered one-hot grant
//   valid           : registered, equals |gnt
//   timeout         : registered one-cycle pulse on a forced release
module burst_rr_arbiter
    import arb_pkg::*;
#(
    parameter int unsigned N         = 4,
    parameter int unsigned MAX_BEATS = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         enable,
    input  logic [N-1:0] req,
    input  logic         beat,
    input  logic [N-1:0] last,
    output logic [N-1:0] gnt,
    output logic         valid,
    output logic         timeout
);

    localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;

`ifdef ARB_TIMEOUT_EN
    localparam logic TIMEOUT_ON = 1'b1;
`else
    localparam logic TIMEOUT_ON = 1'b0;
`endif

    localparam logic [BEAT_CNT_W-1:0] BEAT_LIMIT = BEAT_CNT_W'(MAX_BEATS);

    arb_state_e            state_q, state_d;
    logic [N-1:0]          gnt_q, gnt_d;
    logic                  valid_q, valid_d;
    logic                  timeout_q, timeout_d;
    logic [PW-1:0]         ptr_q, ptr_d;
    logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;

    logic [N-1:0]          pick;
    logic [PW-1:0]         pick_idx;
    logic [BEAT_CNT_W-1:0] cnt_inc;
    logic                  own_req;
    logic                  own_last;
    logic                  limit_hit;

    rr_pick #(
        .N  (N),
        .PW (PW)
    ) u_pick (
        .req  (req),
        .ptr  (ptr_q),
        .pick (pick),
        .idx  (pick_idx)
    );

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        valid_d   = valid_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + BEAT_CNT_W'(1);
        // ptr_q doubles as the owner index while in GRANT
        own_req   = req[ptr_q];
        own_last  = beat & last[ptr_q];
        limit_hit = TIMEOUT_ON & beat & (cnt_inc == BEAT_LIMIT);

        case (state_q)
            IDLE: begin
                if (enable && (|req)) begin
                    state_d = GRANT;
                    gnt_d   = pick;
                    valid_d = 1'b1;
                    ptr_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (beat) begin
                    cnt_d = cnt_inc;
                end
                if (!own_req || own_last || limit_hit) begin
                    state_d   = IDLE;
                    gnt_d     = '0;
                    valid_d   = 1'b0;
                    // a limit beat that also ends the burst is a normal release
                    timeout_d = limit_hit & own_req & ~own_last;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            gnt_q     <= '0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            ptr_q     <= PW'(N - 1);
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            valid_q   <= valid_d;
            timeout_q <= timeout_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
        end
    end

    assign gnt     = gnt_q;
    assign valid   = valid_q;
    assign timeout = timeout_q;

endmodule : burst_rr_arbiter

// File: tb/tb_burst_rr_arbiter.sv
// Directed testbench for burst_rr_arbiter (N=4, MAX_BEATS=8).
// Expected values are hand-derived; build with ARB_TIMEOUT_EN defined to
// exercise the beat-limit path.
module tb_burst_rr_arbiter;

    logic       clk;
    logic       rst_n;
    logic       enable;
    logic [3:0] req;
    logic       beat;
    logic [3:0] last;
    logic [3:0] gnt;
    logic       valid;
    logic       timeout;

    int n_checks;
    int n_pass;
    bit mon_on;

    burst_rr_arbiter #(
        .N         (4),
        .MAX_BEATS (8)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .req     (req),
        .beat    (beat),
        .last    (last),
        .gnt     (gnt),
        .valid   (valid),
        .timeout (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // grant must stay one-hot and valid must track it in every cycle
    always @(negedge clk) begin
        if (mon_on) begin
            check("onehot", 32'($countones(gnt) <= 1), 32'd1);
            check("valid_eq", 32'(valid), 32'(|gnt));
        end
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        mon_on   = 1'b0;
        rst_n    = 1'b1;
        enable   = 1'b0;
        req      = 4'b0000;
        beat     = 1'b0;
        last     = 4'b0000;
        #3 rst_n = 1'b0;
        step();
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_valid", 32'(valid), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        rst_n  = 1'b1;
        mon_on = 1'b1;

        // beat with no owner is ignored
        enable = 1'b1;
        beat   = 1'b1;
        step();
        check("idle_beat", 32'(gnt), 32'h0);
        beat = 1'b0;

        // full rotation starting at requester 0, one idle cycle between grants
        req = 4'b1111;
        begin
            int order [5] = '{0, 1, 2, 3, 0};
            for (int i = 0; i < 5; i++) begin
                step();
                check("rot_gnt", 32'(gnt), 32'(1) << order[i]);
                check("rot_valid", 32'(valid), 32'h1);
                beat = 1'b1;
                last = 4'b1111;
                step();
                check("rot_rel", 32'(gnt), 32'h0);
                beat = 1'b0;
                last = 4'b0000;
            end
        end

        // make requester 1 the last winner, then search wraps from 2
        req = 4'b0010;
        step();
        check("p1_gnt", 32'(gnt), 32'h2);
        beat = 1'b1; last = 4'b0010;
        step();
        beat = 1'b0; last = 4'b0000;
        req = 4'b1001;
        step();
        check("ptr1_gnt", 32'(gnt), 32'h8);
        beat = 1'b1; last = 4'b1000;
        step();
        check("ptr1_rel", 32'(gnt), 32'h0);
        beat = 1'b0; last = 4'b0000;
        step();
        check("ptr3_gnt", 32'(gnt), 32'h1);
        beat = 1'b1; last = 4'b0001;
        step();
        beat = 1'b0; last = 4'b0000;

        // owner 2, enable dropped after the first beat, last on beat 3
        req = 4'b0100;
        step();
        check("en_gnt", 32'(gnt), 32'h4);
        beat = 1'b1;
        step();
        check("en_b1", 32'(gnt), 32'h4);
        enable = 1'b0;
        step();
        check("en_b2", 32'(gnt), 32'h4);
        last = 4'b0100;
        step();
        check("en_b3_rel", 32'(gnt), 32'h0);
        beat = 1'b0; last = 4'b0000;
        step();
        check("en_off_idle", 32'(gnt), 32'h0);
        enable = 1'b1;

        // owner 1 ignores non-owner req/last, then drops its request
        req = 4'b0010;
        step();
        check("drop_gnt", 32'(gnt), 32'h2);
        req  = 4'b1111;
        beat = 1'b1;
        last = 4'b1101;
        step();
        check("nonowner", 32'(gnt), 32'h2);
        beat = 1'b0; last = 4'b0000;
        req  = 4'b0000;
        step();
        check("drop_gnt0", 32'(gnt), 32'h0);
        check("drop_valid", 32'(valid), 32'h0);
        check("drop_tmo", 32'(timeout), 32'h0);

        // owner 0 streams beats without last; requester 1 waiting
        req = 4'b0001;
        step();
        check("str_gnt", 32'(gnt), 32'h1);
        req  = 4'b0011;
        beat = 1'b1;
        for (int b = 1; b <= 7; b++) begin
            step();
            check("str_hold", 32'(gnt), 32'h1);
            check("str_tmo0", 32'(timeout), 32'h0);
        end
        step();
`ifdef ARB_TIMEOUT_EN
        check("tmo_rel", 32'(gnt), 32'h0);
        check("tmo_pulse", 32'(timeout), 32'h1);
        beat = 1'b0;
        step();
        check("tmo_end", 32'(timeout), 32'h0);
        check("tmo_next", 32'(gnt), 32'h2);
`else
        check("nolim_hold", 32'(gnt), 32'h1);
        check("nolim_tmo", 32'(timeout), 32'h0);
        last = 4'b0001;
        step();
        check("nolim_rel", 32'(gnt), 32'h0);
        beat = 1'b0; last = 4'b0000;
        step();
        check("nolim_next", 32'(gnt), 32'h2);
`endif
        req = 4'b0000;
        step();
        check("str_done", 32'(gnt), 32'h0);

        // reset in the middle of a grant to requester 3
        req = 4'b1000;
        step();
        check("r3_gnt", 32'(gnt), 32'h8);
        beat = 1'b1;
        step();
        rst_n = 1'b0;
        #1;
        check("arst_gnt", 32'(gnt), 32'h0);
        check("arst_valid", 32'(valid), 32'h0);
        beat = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        check("post_rst_gnt", 32'(gnt), 32'h8);

        mon_on = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_burst_rr_arbiter
